data_sync_dest: RTL and testbench

//  Destination-side multi-cycle-path (MCP) bus synchronizer; sits directly downstream of the

---
 rtl/data_sync_dest.sv | 107 ++++++++++
 tb/tb_data_sync_dest.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/data_sync_dest.sv
// data_sync_dest: destination-side multi-cycle-path bus synchronizer.
//   Synchronizes the source's BUS_ENABLE toggle through a NUM_STAGES flop chain,
//   turns each level change into a one-cycle strobe, captures UNSYNC_BUS on that
//   strobe and returns a 2-phase acknowledge toggle to the source.
// Ports:
//   CLK          destination clock
//   RST          asynchronous active-low reset
//   UNSYNC_BUS   source-domain data, held stable by the source while a word is in flight
//   BUS_ENABLE   source-domain toggle, one level change per word
//   SYNC_BUS     captured word, held until the next capture
//   ENABLE_PULSE one-cycle strobe coincident with a SYNC_BUS update
//   ACK_TOGGLE   flips once per accepted word
//   CLR_OVERRUN  synchronous clear of OVERRUN
//   OVERRUN      sticky flag: toggles arrived closer than MIN_GAP cycles
// Optional feature: define DATA_SYNC_DEST_OVERRUN_EN to build the gap counter and
// OVERRUN flag; otherwise OVERRUN is tied low and CLR_OVERRUN is ignored.
module data_sync_dest #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8,
    parameter int MIN_GAP    = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 BUS_ENABLE,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 ENABLE_PULSE,
    output logic                 ACK_TOGGLE,
    input  logic                 CLR_OVERRUN,
    output logic                 OVERRUN
);
    if (NUM_STAGES < 2) begin : g_bad_stages
        $error("data_sync_dest: NUM_STAGES must be >= 2");
    end
    if (MIN_GAP < 1) begin : g_bad_gap
        $error("data_sync_dest: MIN_GAP must be >= 1");
    end

    logic [NUM_STAGES-1:0] sync_q, sync_d;
    logic                  prev_q;
    logic                  tgl;
    logic [BUS_WIDTH-1:0]  bus_q, bus_d;
    logic                  pulse_q, pulse_d;
    logic                  ack_q, ack_d;

    // Any level change of the synchronized enable is a new word, rising or falling.
    always_comb begin
        sync_d  = {sync_q[NUM_STAGES-2:0], BUS_ENABLE};
        tgl     = sync_q[NUM_STAGES-1] ^ prev_q;
        bus_d   = tgl ? UNSYNC_BUS : bus_q;
        pulse_d = tgl;
        ack_d   = ack_q ^ tgl;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            bus_q   <= '0;
            pulse_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= sync_q[NUM_STAGES-1];
            bus_q   <= bus_d;
            pulse_q <= pulse_d;
            ack_q   <= ack_d;
        end
    end

    assign SYNC_BUS     = bus_q;
    assign ENABLE_PULSE = pulse_q;
    assign ACK_TOGGLE   = ack_q;

`ifdef DATA_SYNC_DEST_OVERRUN_EN
    localparam int GW = $clog2(MIN_GAP + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(MIN_GAP);

    logic [GW-1:0] gap_q, gap_d;
    logic          ovr_q, ovr_d;

    // gap_q counts idle cycles since the last edge; starting saturated means the
    // first edge after reset can never be flagged. A new set beats a clear.
    always_comb begin
        gap_d = tgl ? '0 : ((gap_q == GAP_MAX) ? gap_q : gap_q + 1'b1);
        ovr_d = (tgl && (int'(gap_q) < MIN_GAP - 1)) ? 1'b1 : (CLR_OVERRUN ? 1'b0 : ovr_q);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            gap_q <= GAP_MAX;
            ovr_q <= 1'b0;
        end else begin
            gap_q <= gap_d;
            ovr_q <= ovr_d;
        end
    end

    assign OVERRUN = ovr_q;
`else
    logic unused_clr;

    assign unused_clr = CLR_OVERRUN;
    assign OVERRUN    = 1'b0;
`endif

endmodule

// File: tb/tb_data_sync_dest.sv
// tb_data_sync_dest: self-checking bench for data_sync_dest (NUM_STAGES=2, BUS_WIDTH=8, MIN_GAP=4).
//   The reference model keeps the history of BUS_ENABLE as seen at each clock and
//   predicts a word whenever the value seen NUM_STAGES clocks ago differs from the
//   one seen a clock earlier; overrun is predicted from the distance between words.
module tb_data_sync_dest;
    localparam int NS = 2;
    localparam int MG = 4;
`ifdef DATA_SYNC_DEST_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] UNSYNC_BUS = '0;
    logic       BUS_ENABLE = 1'b0;
    logic       CLR_OVERRUN = 1'b0;
    logic [7:0] SYNC_BUS;
    logic       ENABLE_PULSE;
    logic       ACK_TOGGLE;
    logic       OVERRUN;

    data_sync_dest #(.NUM_STAGES(NS), .BUS_WIDTH(8), .MIN_GAP(MG)) dut (
        .CLK(CLK),
        .RST(RST),
        .UNSYNC_BUS(UNSYNC_BUS),
        .BUS_ENABLE(BUS_ENABLE),
        .SYNC_BUS(SYNC_BUS),
        .ENABLE_PULSE(ENABLE_PULSE),
        .ACK_TOGGLE(ACK_TOGGLE),
        .CLR_OVERRUN(CLR_OVERRUN),
        .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    int   tests = 0;
    int   fails = 0;
    int   npulse = 0;
    int   cyc = 0;
    int   last_word = -1000;
    bit   hist[$];
    logic [7:0] sync_exp = '0;
    logic pulse_exp = 1'b0;
    logic ack_exp = 1'b0;
    logic ovr_exp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        repeat (NS + 1) hist.push_back(1'b0);
        sync_exp  = '0;
        pulse_exp = 1'b0;
        ack_exp   = 1'b0;
        ovr_exp   = 1'b0;
        last_word = -1000;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".sync_bus"}, 32'(SYNC_BUS), 32'(sync_exp));
        chk({tag, ".pulse"}, 32'(ENABLE_PULSE), 32'(pulse_exp));
        chk({tag, ".ack"}, 32'(ACK_TOGGLE), 32'(ack_exp));
        chk({tag, ".overrun"}, 32'(OVERRUN), 32'(ovr_exp));
    endtask

    task automatic tick(input string tag);
        int n;
        @(posedge CLK);
        cyc++;
        if (!RST) model_reset();
        else begin
            hist.push_back(BUS_ENABLE);
            n = hist.size() - 1;
            pulse_exp = hist[n-NS] != hist[n-NS-1];
            if (pulse_exp) begin
                sync_exp = UNSYNC_BUS;
                ack_exp  = ~ack_exp;
            end
            if (OVR_EN && pulse_exp && (cyc - last_word < MG)) ovr_exp = 1'b1;
            else if (CLR_OVERRUN) ovr_exp = 1'b0;
            if (pulse_exp) last_word = cyc;
        end
        #1;
        if (ENABLE_PULSE === 1'b1) npulse++;
        check_outputs(tag);
    endtask

    task automatic assert_reset(input string tag);
        RST = 1'b0;
        model_reset();
        #1;
        check_outputs(tag);
    endtask

    initial begin
        // 1. async reset without a clock edge
        UNSYNC_BUS = 8'($urandom);
        #2;
        assert_reset("reset");
        tick("reset_hold");
        RST = 1'b1;
        tick("idle");

        // 2. single word: pulse only after the third edge
        UNSYNC_BUS = 8'hA5;
        BUS_ENABLE = 1'b1;
        npulse = 0;
        repeat (3) tick("single");
        chk("single.pulse_at_3", 32'(ENABLE_PULSE), 32'd1);
        chk("single.data", 32'(SYNC_BUS), 32'hA5);
        chk("single.ack", 32'(ACK_TOGGLE), 32'd1);
        repeat (4) tick("single_after");
        chk("single.count", 32'(npulse), 32'd1);

        // 3. stream of three words
        assert_reset("stream_rst");
        BUS_ENABLE = 1'b0;
        RST = 1'b1;
        npulse = 0;
        for (int w = 1; w <= 3; w++) begin
            UNSYNC_BUS = 8'(w);
            BUS_ENABLE = ~BUS_ENABLE;
            repeat (10) tick("stream");
            chk("stream.data", 32'(SYNC_BUS), 32'(w));
            chk("stream.ack", 32'(ACK_TOGGLE), 32'(w % 2));
        end
        chk("stream.count", 32'(npulse), 32'd3);
        chk("stream.overrun", 32'(OVERRUN), 32'd0);

        // 4. bus changes with no toggle
        UNSYNC_BUS = 8'h5A;
        tick("bus_only");
        UNSYNC_BUS = 8'hFF;
        npulse = 0;
        repeat (20) tick("bus_only");
        chk("bus_only.data", 32'(SYNC_BUS), 32'h03);
        chk("bus_only.ack", 32'(ACK_TOGGLE), 32'd1);
        chk("bus_only.count", 32'(npulse), 32'd0);

        // 5a. reset released with BUS_ENABLE high
        assert_reset("rst_high");
        BUS_ENABLE = 1'b1;
        tick("rst_high_hold");
        RST = 1'b1;
        npulse = 0;
        repeat (3) tick("rst_high");
        chk("rst_high.pulse_at_3", 32'(ENABLE_PULSE), 32'd1);
        repeat (5) tick("rst_high_after");
        chk("rst_high.count", 32'(npulse), 32'd1);

        // 5b. reset one cycle after a flip discards it
        BUS_ENABLE = 1'b0;
        tick("rst_mid");
        assert_reset("rst_mid_rst");
        repeat (2) tick("rst_mid_hold");
        RST = 1'b1;
        npulse = 0;
        repeat (6) tick("rst_mid_after");
        chk("rst_mid.count", 32'(npulse), 32'd0);

        // 6. two flips two cycles apart
        assert_reset("ovr_rst");
        RST = 1'b1;
        repeat (2) tick("ovr_idle");
        npulse = 0;
        UNSYNC_BUS = 8'h11;
        BUS_ENABLE = 1'b1;
        repeat (2) tick("ovr");
        UNSYNC_BUS = 8'h22;
        BUS_ENABLE = 1'b0;
        repeat (6) tick("ovr");
        chk("ovr.count", 32'(npulse), 32'd2);
        chk("ovr.data", 32'(SYNC_BUS), 32'h22);
        chk("ovr.flag", 32'(OVERRUN), 32'(OVR_EN));
        CLR_OVERRUN = 1'b1;
        tick("ovr_clr");
        CLR_OVERRUN = 1'b0;
        chk("ovr.cleared", 32'(OVERRUN), 32'd0);
        repeat (3) tick("ovr_after");

        // 7. random toggles, data and clears against the model
        for (int i = 0; i < 500; i++) begin
            UNSYNC_BUS  = 8'($urandom);
            if ($urandom_range(0, 4) == 0) BUS_ENABLE = ~BUS_ENABLE;
            CLR_OVERRUN = ($urandom_range(0, 15) == 0);
            tick("random");
        end
        CLR_OVERRUN = 1'b0;
        repeat (5) tick("drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
